// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants and types used by the ROB, decode and the tag scheduler.
package rob_pkg;

    localparam int unsigned ROB_ENTRIES  = 4;
    localparam int unsigned ID_WIDTH     = 2;
    localparam int unsigned FLUSH_CYCLES = 2;

    typedef logic [ID_WIDTH-1:0] rob_id_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rob_tag_scheduler.sv
// In-order ROB instruction-ID allocator with retirement-order checking and
// exception-driven flush sequencing.
module rob_tag_scheduler
    import rob_pkg::*;
#(
    parameter int unsigned ROB_ENTRIES  = rob_pkg::ROB_ENTRIES,
    parameter int unsigned ID_WIDTH     = rob_pkg::ID_WIDTH,
    parameter int unsigned FLUSH_CYCLES = rob_pkg::FLUSH_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_req,
    output logic                issue_grant,
    output logic [ID_WIDTH-1:0] issue_id,
    output logic                issue_stall,
    input  logic                rob_full,
    input  logic                retire_valid,
    input  logic [ID_WIDTH-1:0] retire_id,
    input  logic                xcpt_valid,
    output logic                invalidate_buffer,
    output logic                flush_pipeline,
    output logic [ID_WIDTH:0]   inflight_count,
    output logic                rob_empty,
    output logic                retire_error
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    sched_state_t        state_q, state_d;
    logic [ID_WIDTH-1:0] head_q, head_d;
    logic [ID_WIDTH-1:0] tail_q, tail_d;
    logic [ID_WIDTH:0]   count_q, count_d;
    logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic                inval_q, inval_d;
    logic                flushp_q, flushp_d;
    logic                err_q, err_d;

    logic                grant;
    logic                retire_ok;

    // Grant/retire qualification; fullness uses the registered count only.
    always_comb begin
        grant     = issue_req && (state_q == RUN)
                    && (count_q < (ID_WIDTH+1)'(ROB_ENTRIES))
                    && !rob_full && !xcpt_valid;
        retire_ok = (state_q == RUN) && retire_valid
                    && (retire_id == tail_q) && (count_q != '0);
    end

    // Next-state logic for pointers, count, flush sequencing and sticky error.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        flush_cnt_d = flush_cnt_q;
        inval_d     = inval_q;
        flushp_d    = 1'b0;
        err_d       = err_q;
        unique case (state_q)
            RUN: begin
                if (retire_valid && !retire_ok) begin
                    err_d = 1'b1;
                end
                if (xcpt_valid) begin
                    // A same-cycle good retire is accepted but its effect is
                    // discarded by the pointer/count clear.
                    state_d     = FLUSH;
                    head_d      = '0;
                    tail_d      = '0;
                    count_d     = '0;
                    inval_d     = 1'b1;
                    flushp_d    = 1'b1;
                    flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
                end else begin
                    inval_d = 1'b0;
                    if (grant) begin
                        head_d = head_q + ID_WIDTH'(1);
                    end
                    if (retire_ok) begin
                        tail_d = tail_q + ID_WIDTH'(1);
                    end
                    if (grant && !retire_ok) begin
                        count_d = count_q + (ID_WIDTH+1)'(1);
                    end else if (!grant && retire_ok) begin
                        count_d = count_q - (ID_WIDTH+1)'(1);
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = RUN;
                    inval_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
            inval_q     <= 1'b0;
            flushp_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
            inval_q     <= inval_d;
            flushp_q    <= flushp_d;
            err_q       <= err_d;
        end
    end

    // Output mapping.
    always_comb begin
        issue_grant       = grant;
        issue_id          = head_q;
        issue_stall       = issue_req && !grant;
        invalidate_buffer = inval_q;
        flush_pipeline    = flushp_q;
        inflight_count    = count_q;
        rob_empty         = (count_q == '0);
        retire_error      = err_q;
    end

endmodule

// File: tb/tb_rob_tag_scheduler.sv
// Scoreboard bench for rob_tag_scheduler: directed scenarios plus random traffic
// checked against a queue-based model of in-flight IDs.
module tb_rob_tag_scheduler;
    import rob_pkg::*;

    localparam int N  = rob_pkg::ROB_ENTRIES;
    localparam int FC = rob_pkg::FLUSH_CYCLES;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          issue_req = 1'b0;
    logic          issue_grant;
    logic [1:0]    issue_id;
    logic          issue_stall;
    logic          rob_full = 1'b0;
    logic          retire_valid = 1'b0;
    logic [1:0]    retire_id = '0;
    logic          xcpt_valid = 1'b0;
    logic          invalidate_buffer;
    logic          flush_pipeline;
    logic [2:0]    inflight_count;
    logic          rob_empty;
    logic          retire_error;

    rob_tag_scheduler #(
        .ROB_ENTRIES (N),
        .ID_WIDTH    (2),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .issue_req        (issue_req),
        .issue_grant      (issue_grant),
        .issue_id         (issue_id),
        .issue_stall      (issue_stall),
        .rob_full         (rob_full),
        .retire_valid     (retire_valid),
        .retire_id        (retire_id),
        .xcpt_valid       (xcpt_valid),
        .invalidate_buffer(invalidate_buffer),
        .flush_pipeline   (flush_pipeline),
        .inflight_count   (inflight_count),
        .rob_empty        (rob_empty),
        .retire_error     (retire_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int grant;
        int id;
        int stall;
        int inval;
        int flushp;
        int count;
        int empty;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 1'b0;

    // Reference model: IDs in flight in program order, remaining flush cycles.
    int   m_inflight[$];
    int   m_next_id;
    int   m_flush_left;
    bit   m_flushp;
    bit   m_err;

    function automatic void model_reset();
        m_inflight.delete();
        m_next_id    = 0;
        m_flush_left = 0;
        m_flushp     = 1'b0;
        m_err        = 1'b0;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // One clock cycle of stimulus; computes the expected outputs from the model.
    task automatic drive(input bit rst, input bit req, input bit full,
                         input bit rv, input int rid, input bit x);
        exp_t e;
        bit   run, ok;
        @(posedge clock);
        #1;
        reset        = rst;
        issue_req    = req;
        rob_full     = full;
        retire_valid = rv;
        retire_id    = 2'(rid);
        xcpt_valid   = x;
        if (rst) begin
            model_reset();
        end else begin
            run      = (m_flush_left == 0);
            e.grant  = (req && run && m_inflight.size() < N && !full && !x) ? 1 : 0;
            e.id     = m_next_id;
            e.stall  = (req && e.grant == 0) ? 1 : 0;
            e.inval  = (m_flush_left > 0) ? 1 : 0;
            e.flushp = m_flushp;
            e.count  = m_inflight.size();
            e.empty  = (m_inflight.size() == 0) ? 1 : 0;
            e.err    = m_err;
            exp_q.push_back(e);
            if (run) begin
                ok = rv && m_inflight.size() > 0 && m_inflight[0] == rid;
                if (rv && !ok) m_err = 1'b1;
                if (x) begin
                    m_inflight.delete();
                    m_next_id    = 0;
                    m_flush_left = FC;
                    m_flushp     = 1'b1;
                end else begin
                    if (ok) void'(m_inflight.pop_front());
                    if (e.grant == 1) begin
                        m_inflight.push_back(m_next_id);
                        m_next_id = (m_next_id + 1) % N;
                    end
                    m_flushp = 1'b0;
                end
            end else begin
                m_flush_left--;
                m_flushp = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares the DUT against the oldest pending expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue_grant", int'(issue_grant), e.grant);
                if (e.grant == 1) chk("issue_id", int'(issue_id), e.id);
                chk("issue_stall", int'(issue_stall), e.stall);
                chk("invalidate_buffer", int'(invalidate_buffer), e.inval);
                chk("flush_pipeline", int'(flush_pipeline), e.flushp);
                chk("inflight_count", int'(inflight_count), e.count);
                chk("rob_empty", int'(rob_empty), e.empty);
                chk("retire_error", int'(retire_error), e.err);
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic with occasional resets.
    initial begin
        int rid;
        model_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        // Fill: IDs 0..3 then stall at count 4.
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 0);
        // Retire 0,1; full and retire together at count 4 gives no grant.
        drive(0, 1, 0, 1, 0, 0);
        drive(0, 1, 0, 1, 1, 0);
        // Simultaneous issue/retire.
        drive(0, 1, 0, 1, 2, 0);
        // rob_full override, then release.
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        // Exception with issue_req held through the flush window.
        drive(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < FC + 2; i++) drive(0, 1, 0, 1, 3, 1);
        // Out-of-order retire sets the sticky error.
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0);
        idle(3);
        // Reset on the second flush cycle.
        drive(0, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        idle(3);
        // Retire with nothing in flight.
        drive(0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 8 && m_inflight.size() > 0) rid = m_inflight[0];
            else rid = int'($urandom_range(0, N - 1));
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 1),
                  ($urandom_range(0, 9) < 4),
                  rid,
                  ($urandom_range(0, 49) == 0));
        end
        idle(2);
        stim_done = 1'b1;
    end

    // Completion with a bounded wait for the scoreboard to drain.
    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clock);
            budget++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout at %0t: got running expected finished", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rob_tag_scheduler.md
Name: rob_tag_scheduler

Overview:
- Allocates reorder-buffer instruction IDs to the decode/issue stage, in order.
- Tracks in-flight count and the expected retirement order.
- On a committed exception, sequences the ROB flush: drives the reorder buffer's invalidate_buffer and a pipeline-flush pulse, then blocks issue until the flush window ends.
- Sits between decode and the reorder buffer / execution units. It is the single owner of ROB slot allocation.

Parameters:
- ROB_ENTRIES, 4, number of reorder-buffer slots; power of two.
- ID_WIDTH, 2, instruction-ID width; equals log2(ROB_ENTRIES).
- FLUSH_CYCLES, 2, cycles invalidate_buffer stays asserted after an exception; must be at least 1.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_req  in  1  decode requests an ID for a new instruction.
- issue_grant  out  1  ID granted this cycle (combinational).
- issue_id  out  ID_WIDTH  ID assigned to the granted instruction (equals head pointer).
- issue_stall  out  1  issue_req present but not granted.
- rob_full  in  1  full flag from the reorder buffer.
- retire_valid  in  1  reorder buffer commits an instruction this cycle.
- retire_id  in  ID_WIDTH  ID of the committed instruction.
- xcpt_valid  in  1  committed instruction raised an exception.
- invalidate_buffer  out  1  clear the reorder buffer; registered.
- flush_pipeline  out  1  one-cycle pulse to squash the fetch/decode/execute stages; registered.
- inflight_count  out  ID_WIDTH+1  number of allocated, not-yet-retired IDs.
- rob_empty  out  1  inflight_count == 0.
- retire_error  out  1  sticky: a retirement arrived out of order or with nothing in flight.

Behaviour:
- State: head_ff, tail_ff (ID_WIDTH bits, wrap modulo ROB_ENTRIES), count_ff (ID_WIDTH+1 bits), FSM {RUN, FLUSH}, flush_cnt_ff.
- Reset values: state RUN; head, tail, count, flush_cnt = 0. invalidate_buffer, flush_pipeline, retire_error = 0. Hence inflight_count = 0 and rob_empty = 1.
- Grant: issue_grant = issue_req & state==RUN & count_ff < ROB_ENTRIES & !rob_full & !xcpt_valid.
  - issue_id = head_ff, valid in the same cycle.
  - On grant, head_ff <= head_ff+1 (ROB_ENTRIES-1 wraps to 0).
- issue_stall = issue_req & !issue_grant.
- Retire, in RUN only:
  - If retire_valid & retire_id == tail_ff & count_ff != 0: tail_ff increments with wrap, count decrements.
  - Otherwise retire_valid sets retire_error; retire_error clears only on reset. tail and count are unchanged on error.
- Grant and retire in the same cycle: count unchanged, both pointers advance.
- Count never exceeds ROB_ENTRIES. At count == ROB_ENTRIES with retire in the same cycle there is still no grant, because count is checked before the update (registered-full semantics).
- xcpt_valid in RUN (takes priority over grant; retire in the same cycle is accepted, then discarded):
  - Next cycle: state FLUSH; head, tail, count <= 0.
  - invalidate_buffer <= 1; flush_pipeline <= 1 for exactly one cycle; flush_cnt <= FLUSH_CYCLES-1.
- FLUSH state:
  - invalidate_buffer held at 1; issue_grant = 0; retire_valid and xcpt_valid ignored (no error logged).
  - flush_cnt decrements each cycle. When it reaches 0, the next cycle is RUN with invalidate_buffer = 0.
  - invalidate_buffer is high for exactly FLUSH_CYCLES cycles.
- Reset asserted mid-FLUSH: returns to RUN next edge with all outputs at reset values.
- Latencies:
  - grant to issue_id: 0 cycles.
  - xcpt_valid to invalidate_buffer/flush_pipeline: 1 cycle.
  - first possible grant after xcpt: FLUSH_CYCLES+1 cycles.

Decomposition:
- Shared package rob_pkg:
  - ROB_ENTRIES and ID_WIDTH constants, shared with reorder_buffer and decode.
  - rob_id_t typedef.
  - sched_state_t enum {RUN, FLUSH}.
- Single module, no sub-module. The pointer wrap is plain modulo-2^ID_WIDTH arithmetic.

Test Plan:
- Fill: after reset, hold issue_req=1 with no retire → grants IDs 0,1,2,3 on four consecutive cycles; cycle 5 issue_stall=1, inflight_count=4.
- Wrap with simultaneous issue/retire: at count=3, tail=1, head=0 → assert issue_req and retire_valid(retire_id=1) together → grant id 0, count stays 3, tail=2, head=1.
- Out-of-order retire: count=2, tail=0 → retire_valid with retire_id=1 → retire_error=1 next cycle and stays high; tail=0, count=2.
- Exception flush (FLUSH_CYCLES=2): count=3, pulse xcpt_valid while issue_req=1 → no grant that cycle; next cycle invalidate_buffer=1 and flush_pipeline=1, count=0; invalidate_buffer high for 2 cycles; first grant 3 cycles after xcpt, with issue_id=0.
- rob_full override: count=1, rob_full=1, issue_req=1 → issue_grant=0, issue_stall=1; drop rob_full → grant id 1.
- Reset mid-flush: reset asserted on second FLUSH cycle → next edge state RUN, invalidate_buffer=0, rob_empty=1, retire_error=0.
